axis_rr_arbiter: RTL and testbench
==================================

// Module: axis_rr_arbiter
// PURPOSE
// - Shares one registered AXI-Stream output among N AXI-Stream requesters.
// - Fair round-robin arbitration; the output stage is a single register slice (1-beat buffer).
// - Sits in front of shared consumers, e.g. a memory port fed by the I- and D-side streams.
// - Reports the winning requester index alongside the data.
// PARAMETERS
// - N_REQ        4   number of requester ports, >= 2
// - TDATA_WIDTH  32  data width of every stream, > 0
// - MAX_BURST    4   maximum consecutive beats per grant; used only with AXIS_ARB_BURST_EN; >= 1
// PORTS
// - clk       in   1                    clock, all logic on posedge
// - rst       in   1                    synchronous, active-high reset
// - s_tvalid  in   N_REQ                per-requester valid
// - s_tdata   in   N_REQ*TDATA_WIDTH    per-requester data; requester i in slice [i*W +: W]
// - s_tready  out  N_REQ                per-requester ready
// - m_tvalid  out  1                    output valid (registered)
// - m_tdata   out  TDATA_WIDTH          output data (registered)
// - m_tid     out  $clog2(N_REQ)        index of the requester that produced m_tdata (registered)
// - m_tready  in   1                    output ready
// - flush     in   1                    drops the held output beat
// BEHAVIOUR
// - Reset values:
//   - m_tvalid=0, m_tdata=0, m_tid=0.
//   - Last-grant pointer ptr=N_REQ-1, so requester 0 has first priority; burst count=0.
// - Accept: accept = !m_tvalid || m_tready, forced to 0 while flush=1.
// - Grant (combinational):
//   - Search requesters ptr+1, ptr+2, ... modulo N_REQ.
//   - Pick the first one with s_tvalid=1; no grant if none is valid.
// - Ready: s_tready[i] = accept && granted==i.
//   - At most one s_tready is high; s_tready never depends on m_tvalid of another port.
// - On a transfer (accept and a grant exists):
//   - m_tvalid<=1, m_tdata<=the winner's s_tdata, m_tid<=the winner's index.
//   - ptr<=the winner's index.
// - No grant while accept=1: m_tvalid<=0; m_tdata and m_tid hold their values.
// - Latency and throughput:
//   - Input beat to m_tvalid: 1 cycle.
//   - Full throughput of 1 beat/cycle while m_tready=1.
// - Backpressure:
//   - While m_tvalid=1 and m_tready=0, the output register holds and all s_tready=0.
//   - The m_* outputs stay stable until the handshake completes.
// - flush=1: m_tvalid<=0 next cycle; no input is accepted; ptr and burst count are unchanged.
// - Simultaneous m_tready and new input: the old beat leaves and the new beat loads in the same cycle.
// - Pointer wrap: ptr=N_REQ-1 wraps the search to requester 0.
// - Reset mid-stream: the in-flight output beat is discarded; arbitration restarts at requester 0.
// CONFIGURATION
// - Macro AXIS_ARB_BURST_EN defined:
//   - A burst counter cnt (width $clog2(MAX_BURST+1)) is added.
//   - If the previous winner ptr still has s_tvalid=1 and cnt<MAX_BURST, it is granted again.
//     Otherwise the round-robin search starts at ptr+1.
//   - cnt<=1 on a grant to a new requester; cnt<=cnt+1 on a repeat grant to the same requester.
//   - cnt<=0 when no grant occurs while accept=1.
//   - With MAX_BURST=1 the behaviour is identical to the macro being undefined.
// - Macro AXIS_ARB_BURST_EN undefined:
//   - Strict per-beat round-robin; no counter logic; the MAX_BURST parameter is ignored.
// STRUCTURE
// - Shared package axis_arb_pkg:
//   - Default constants AXIS_ARB_N_REQ=4 and AXIS_ARB_TDATA_W=32.
//   - Function rr_next(ptr, req) returning the winning index and a found flag.
// - Sub-module axis_rr_pick: purely combinational rotating-priority picker.
//   - Inputs: req vector, ptr.
//   - Outputs: one-hot grant, grant index, any.
//   - Instantiated once.
// - Top level contains the output register, the ptr/cnt registers and the s_tready fan-out.
// TESTING (N_REQ=4, TDATA_WIDTH=32, MAX_BURST=2)
// - Reset, then all s_tvalid=1 with s_tdata[i]=0x10+i and m_tready=1 held
//   -> m_tid sequence 0,1,2,3,0.
//   -> m_tdata sequence 0x10,0x11,0x12,0x13,0x10.
// - Only requester 2 valid, m_tready=1 -> one beat per cycle, all m_tid=2, s_tready=4'b0100 each cycle.
// - Beat 0xAA loaded, m_tready=0 for 3 cycles -> m_tvalid=1 and m_tdata=0xAA stable; s_tready=0.
//   - Then m_tready=1 -> 0xAA consumed and the next beat loaded in the same cycle.
// - m_tvalid=1 with beat 0x55, flush=1 for 1 cycle -> next cycle m_tvalid=0; 0x55 never handshakes;
//   no s_tready asserted during the flush.
// - Requesters 1 and 3 valid, ptr=3 -> requester 1 wins; ptr=1 -> requester 3 wins (wrap check).
// - With AXIS_ARB_BURST_EN, all valid -> m_tid 0,0,1,1,2,2,3,3.
//   - Without the macro -> 0,1,2,3.
// - Scoreboard: every accepted s_tdata appears exactly once on m_tdata with the correct m_tid.
// - Per-requester order is preserved.
// - Assertions: $onehot0(s_tready) every cycle; m_* stable while m_tvalid && !m_tready.

Source files
------------

// File: rtl/axis_arb_pkg.sv
// -----------------------------------------------------------------------------
// axis_arb_pkg
// Shared constants, types and the rotating-priority search function used by the
// AXI-Stream round-robin arbiter (axis_rr_arbiter) and its picker (axis_rr_pick).
//
// Contents:
//   AXIS_ARB_N_REQ    default number of requesters
//   AXIS_ARB_TDATA_W  default stream data width
//   AXIS_ARB_MAX_REQ  largest requester count the search function supports
//   rr_result_t       {found, idx} result of a round-robin search
//   rr_next()         first requester with req=1 after ptr, wrapping modulo n
// -----------------------------------------------------------------------------
package axis_arb_pkg;

    localparam int AXIS_ARB_N_REQ   = 4;
    localparam int AXIS_ARB_TDATA_W = 32;

    // The search works on a fixed-width request vector so one function serves
    // every instance; arbiters wider than this are not supported.
    localparam int AXIS_ARB_MAX_REQ = 32;
    localparam int AXIS_ARB_IDX_W   = 5;
    localparam int AXIS_ARB_CAND_W  = AXIS_ARB_IDX_W + 1;

    typedef struct packed {
        logic                      found;
        logic [AXIS_ARB_IDX_W-1:0] idx;
    } rr_result_t;

    // Scan ptr+1, ptr+2, ... (mod n) and return the first requester with req=1.
    // ptr must be < n; the candidate is at most 2n-1, so one conditional
    // subtraction replaces a true modulo.
    function automatic rr_result_t rr_next(
        input int                          n,
        input logic [AXIS_ARB_IDX_W-1:0]   ptr,
        input logic [AXIS_ARB_MAX_REQ-1:0] req
    );
        rr_result_t                 res;
        logic [AXIS_ARB_CAND_W-1:0] cand;
        res = '0;
        for (int k = 1; k <= AXIS_ARB_MAX_REQ; k++) begin
            cand = {1'b0, ptr} + AXIS_ARB_CAND_W'(k);
            if (cand >= AXIS_ARB_CAND_W'(n)) begin
                cand = cand - AXIS_ARB_CAND_W'(n);
            end
            if ((k <= n) && !res.found && req[cand[AXIS_ARB_IDX_W-1:0]]) begin
                res.found = 1'b1;
                res.idx   = cand[AXIS_ARB_IDX_W-1:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/axis_rr_pick.sv
// -----------------------------------------------------------------------------
// axis_rr_pick
// Purely combinational rotating-priority picker. The requester after ptr has
// the highest priority, wrapping from N_REQ-1 back to 0.
//
// Ports:
//   req        in   N_REQ   request vector
//   ptr        in   IDX_W   index of the last winner
//   grant      out  N_REQ   one-hot grant (all zero when nothing requests)
//   grant_idx  out  IDX_W   index of the granted requester
//   any        out  1       at least one requester granted
// -----------------------------------------------------------------------------
module axis_rr_pick
    import axis_arb_pkg::*;
#(
    parameter int N_REQ = AXIS_ARB_N_REQ,
    parameter int IDX_W = $clog2(AXIS_ARB_N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any
);

    logic [AXIS_ARB_MAX_REQ-1:0] req_ext;
    rr_result_t                  res;

    assign req_ext   = AXIS_ARB_MAX_REQ'(req);
    assign res       = rr_next(N_REQ, AXIS_ARB_IDX_W'(ptr), req_ext);
    assign any       = res.found;
    assign grant_idx = res.idx[IDX_W-1:0];

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_grant
            assign grant[gi] = res.found && (res.idx == AXIS_ARB_IDX_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/axis_rr_arbiter.sv
// -----------------------------------------------------------------------------
// axis_rr_arbiter
// Shares one registered AXI-Stream output among N_REQ AXI-Stream requesters
// with fair round-robin arbitration. The output is a single register slice;
// m_tid reports which requester produced the beat.
//
// Optional feature: define AXIS_ARB_BURST_EN to let the last winner keep the
// grant for up to MAX_BURST consecutive beats. Undefined (default): strict
// per-beat round-robin and MAX_BURST has no effect.
//
// Ports:
//   clk       in   1                    clock, posedge
//   rst       in   1                    synchronous active-high reset
//   s_tvalid  in   N_REQ                per-requester valid
//   s_tdata   in   N_REQ*TDATA_WIDTH    requester i in [i*TDATA_WIDTH +: TDATA_WIDTH]
//   s_tready  out  N_REQ                per-requester ready (at most one high)
//   m_tvalid  out  1                    output valid (registered)
//   m_tdata   out  TDATA_WIDTH          output data (registered)
//   m_tid     out  $clog2(N_REQ)        winning requester index (registered)
//   m_tready  in   1                    output ready
//   flush     in   1                    drops the held output beat
// -----------------------------------------------------------------------------
module axis_rr_arbiter
    import axis_arb_pkg::*;
#(
    parameter int N_REQ       = AXIS_ARB_N_REQ,
    parameter int TDATA_WIDTH = AXIS_ARB_TDATA_W,
    parameter int MAX_BURST   = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_REQ-1:0]             s_tvalid,
    input  logic [N_REQ*TDATA_WIDTH-1:0] s_tdata,
    output logic [N_REQ-1:0]             s_tready,
    output logic                         m_tvalid,
    output logic [TDATA_WIDTH-1:0]       m_tdata,
    output logic [$clog2(N_REQ)-1:0]     m_tid,
    input  logic                         m_tready,
    input  logic                         flush
);

    localparam int              IDX_W   = $clog2(N_REQ);
    localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(N_REQ - 1);

    genvar gi;

    logic                   m_tvalid_reg;
    logic [TDATA_WIDTH-1:0] m_tdata_reg;
    logic [IDX_W-1:0]       m_tid_reg;
    logic [IDX_W-1:0]       ptr_reg;

    logic                   accept;
    logic [N_REQ-1:0]       pick_grant;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_any;
    logic [N_REQ-1:0]       win_grant;
    logic [IDX_W-1:0]       win_idx;
    logic                   win_any;

    logic [TDATA_WIDTH-1:0] s_data_arr [N_REQ];

    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign s_data_arr[gi] = s_tdata[gi*TDATA_WIDTH +: TDATA_WIDTH];
        end
    endgenerate

    // The slice can take a beat when empty or when its beat leaves this cycle.
    assign accept = (!m_tvalid_reg || m_tready) && !flush;

    axis_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req       (s_tvalid),
        .ptr       (ptr_reg),
        .grant     (pick_grant),
        .grant_idx (pick_idx),
        .any       (pick_any)
    );

`ifdef AXIS_ARB_BURST_EN
    localparam int               CNT_W   = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic [N_REQ-1:0] ptr_onehot;
    logic             hold_ptr;

    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_ptr_onehot
            assign ptr_onehot[gi] = (ptr_reg == IDX_W'(gi));
        end
    endgenerate

    // cnt=0 means the last winner has no live burst (after reset or an idle
    // accept cycle), so the pointer requester gets no head start then. This
    // also makes MAX_BURST=1 behave exactly like plain round-robin.
    assign hold_ptr  = s_tvalid[ptr_reg] && (cnt_reg != '0) && (cnt_reg < CNT_MAX);
    assign win_grant = hold_ptr ? ptr_onehot : pick_grant;
    assign win_idx   = hold_ptr ? ptr_reg    : pick_idx;
    assign win_any   = hold_ptr || pick_any;

    // Repeat grants saturate at CNT_MAX; any value >= CNT_MAX already blocks
    // the hold, so saturating only keeps the counter from wrapping back to 1.
    always_comb begin
        cnt_next = cnt_reg;
        if (accept) begin
            if (win_any) begin
                if (win_idx == ptr_reg) begin
                    cnt_next = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + CNT_W'(1);
                end else begin
                    cnt_next = CNT_W'(1);
                end
            end else begin
                cnt_next = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end
`else
    // Without bursting, MAX_BURST has no function.
    logic unused_max_burst;
    assign unused_max_burst = (MAX_BURST > 0);

    assign win_grant = pick_grant;
    assign win_idx   = pick_idx;
    assign win_any   = pick_any;
`endif

    assign s_tready = accept ? win_grant : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            m_tvalid_reg <= 1'b0;
            m_tdata_reg  <= '0;
            m_tid_reg    <= '0;
            ptr_reg      <= PTR_RST;
        end else if (accept) begin
            if (win_any) begin
                m_tvalid_reg <= 1'b1;
                m_tdata_reg  <= s_data_arr[win_idx];
                m_tid_reg    <= win_idx;
                ptr_reg      <= win_idx;
            end else begin
                m_tvalid_reg <= 1'b0;
            end
        end else if (flush) begin
            m_tvalid_reg <= 1'b0;
        end
    end

    assign m_tvalid = m_tvalid_reg;
    assign m_tdata  = m_tdata_reg;
    assign m_tid    = m_tid_reg;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axis_rr_arbiter
// Self-checking bench for axis_rr_arbiter (N_REQ=4, TDATA_WIDTH=32, MAX_BURST=2).
// Honours AXIS_ARB_BURST_EN in its expectations when the macro is defined.
// -----------------------------------------------------------------------------
module tb_axis_rr_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int MB = 2;
    localparam int IW = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   s_tvalid = '0;
    logic [N*W-1:0] s_tdata = '0;
    logic [N-1:0]   s_tready;
    logic           m_tvalid;
    logic [W-1:0]   m_tdata;
    logic [IW-1:0]  m_tid;
    logic           m_tready = 1'b0;
    logic           flush = 1'b0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    axis_rr_arbiter #(
        .N_REQ       (N),
        .TDATA_WIDTH (W),
        .MAX_BURST   (MB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .s_tvalid (s_tvalid),
        .s_tdata  (s_tdata),
        .s_tready (s_tready),
        .m_tvalid (m_tvalid),
        .m_tdata  (m_tdata),
        .m_tid    (m_tid),
        .m_tready (m_tready),
        .flush    (flush)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic          mv   = 1'b0;
    logic [W-1:0]  md   = '0;
    int            mt   = 0;
    int            mptr = N - 1;
    int            mcnt = 0;

    typedef struct {
        int           id;
        logic [W-1:0] data;
    } beat_t;
    beat_t sb[$];

    // Who should be granted given the valids: -1 when nobody.
    function automatic int model_winner(input logic [N-1:0] v);
`ifdef AXIS_ARB_BURST_EN
        if (mcnt > 0 && mcnt < MB && v[mptr]) return mptr;
`endif
        for (int k = 1; k <= N; k++) begin
            if (v[(mptr + k) % N]) return (mptr + k) % N;
        end
        return -1;
    endfunction

    always @(negedge clk) begin : compare
        int           w;
        int           idx;
        bit           acc;
        logic [N-1:0] er;
        chk("m_tvalid", 64'(m_tvalid), 64'(mv));
        chk("m_tdata", 64'(m_tdata), 64'(md));
        chk("m_tid", 64'(m_tid), 64'(mt));
        acc = (!mv || m_tready) && !flush;
        w   = model_winner(s_tvalid);
        er  = '0;
        if (acc && w >= 0) er[w] = 1'b1;
        chk("s_tready", 64'(s_tready), 64'(er));

        if (rst) begin
            sb.delete();
            mv = 1'b0; md = '0; mt = 0; mptr = N - 1; mcnt = 0;
        end else begin
            if (m_tvalid && (m_tready || flush)) begin
                idx = -1;
                for (int j = 0; j < sb.size(); j++) begin
                    if (sb[j].id == int'(m_tid)) begin
                        idx = j;
                        break;
                    end
                end
                if (idx < 0) begin
                    chk("sb_missing", 64'(m_tdata), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    chk("sb_data", 64'(m_tdata), 64'(sb[idx].data));
                    sb.delete(idx);
                end
                if (m_tready) $display("beat tid=%0d data=%08h", m_tid, m_tdata);
                else          $display("flushed tid=%0d data=%08h", m_tid, m_tdata);
            end
            for (int i = 0; i < N; i++) begin
                if (s_tvalid[i] && s_tready[i]) sb.push_back('{i, s_tdata[i*W +: W]});
            end
            if (acc) begin
                if (w >= 0) begin
                    mv   = 1'b1;
                    md   = s_tdata[w*W +: W];
                    mt   = w;
                    mcnt = (w == mptr) ? mcnt + 1 : 1;
                    mptr = w;
                end else begin
                    mv   = 1'b0;
                    mcnt = 0;
                end
            end else if (flush) begin
                mv = 1'b0;
            end
        end
    end

    a_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(s_tready))
        else begin
            failures++;
            $display("FAIL onehot0 s_tready=%b", s_tready);
        end

    a_stable: assert property (@(posedge clk) disable iff (rst)
        (m_tvalid && !m_tready && !flush) |=> (m_tvalid && $stable(m_tdata) && $stable(m_tid)))
        else begin
            failures++;
            $display("FAIL stable m_tdata=%08h m_tid=%0d", m_tdata, m_tid);
        end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    int exp_seq [8];

    initial begin
`ifdef AXIS_ARB_BURST_EN
        exp_seq = '{0, 0, 1, 1, 2, 2, 3, 3};
`else
        exp_seq = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif
        rst = 1'b1;
        repeat (3) cyc();
        chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_m_tdata", 64'(m_tdata), 64'd0);
        chk("rst_m_tid", 64'(m_tid), 64'd0);

        // All requesters valid, round-robin order.
        rst = 1'b0;
        for (int i = 0; i < N; i++) s_tdata[i*W +: W] = 32'h10 + 32'(i);
        s_tvalid = '1;
        m_tready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cyc();
            chk("seq_tvalid", 64'(m_tvalid), 64'd1);
            chk("seq_tid", 64'(m_tid), 64'(exp_seq[k]));
            chk("seq_tdata", 64'(m_tdata), 64'h10 + 64'(exp_seq[k]));
        end

        // Single requester 2 streams at full rate.
        s_tvalid = 4'b0100;
        for (int k = 0; k < 4; k++) begin
            s_tdata[2*W +: W] = 32'h200 + 32'(k);
            #1;
            chk("solo_ready", 64'(s_tready), 64'b0100);
            cyc();
            chk("solo_tid", 64'(m_tid), 64'd2);
            chk("solo_tdata", 64'(m_tdata), 64'h200 + 64'(k));
        end

        // Backpressure: 0xAA held for 3 cycles, then replaced by 0xBB in one edge.
        s_tvalid = '0;
        cyc();
        chk("drain_tvalid", 64'(m_tvalid), 64'd0);
        s_tdata[0 +: W] = 32'hAA;
        s_tvalid = 4'b0001;
        m_tready = 1'b0;
        cyc();
        s_tdata[0 +: W] = 32'hBB;
        for (int k = 0; k < 3; k++) begin
            chk("bp_tvalid", 64'(m_tvalid), 64'd1);
            chk("bp_tdata", 64'(m_tdata), 64'hAA);
            chk("bp_ready", 64'(s_tready), 64'd0);
            cyc();
        end
        m_tready = 1'b1;
        #1;
        chk("bp_release_ready", 64'(s_tready), 64'b0001);
        cyc();
        chk("bp_next_tdata", 64'(m_tdata), 64'hBB);
        chk("bp_next_tvalid", 64'(m_tvalid), 64'd1);

        // Flush drops 0x55; no input accepted while flushing.
        s_tvalid = '0;
        cyc();
        s_tdata[0 +: W] = 32'h55;
        s_tvalid = 4'b0001;
        m_tready = 1'b0;
        cyc();
        chk("fl_loaded", 64'(m_tdata), 64'h55);
        s_tdata[0 +: W] = 32'h66;
        flush = 1'b1;
        #1;
        chk("fl_ready", 64'(s_tready), 64'd0);
        cyc();
        chk("fl_tvalid", 64'(m_tvalid), 64'd0);
        flush = 1'b0;
        s_tvalid = '0;
        cyc();

        // Pointer wrap: ptr=3 -> requester 1, then ptr=1 -> requester 3.
        m_tready = 1'b1;
        s_tvalid = 4'b1000;
        cyc();
        chk("wrap_set_tid", 64'(m_tid), 64'd3);
        s_tvalid = '0;
        cyc();
        s_tvalid = 4'b1010;
        #1;
        chk("wrap_ready_a", 64'(s_tready), 64'b0010);
        cyc();
        chk("wrap_tid_a", 64'(m_tid), 64'd1);
        s_tvalid = '0;
        cyc();
        s_tvalid = 4'b1010;
        #1;
        chk("wrap_ready_b", 64'(s_tready), 64'b1000);
        cyc();
        chk("wrap_tid_b", 64'(m_tid), 64'd3);

        // Reset mid-stream discards the held beat and restarts at requester 0.
        s_tvalid = '1;
        m_tready = 1'b0;
        cyc();
        rst = 1'b1;
        cyc();
        chk("mid_rst_tvalid", 64'(m_tvalid), 64'd0);
        rst = 1'b0;
        m_tready = 1'b1;
        cyc();
        chk("mid_rst_tid", 64'(m_tid), 64'd0);

        // Random traffic against the model and scoreboard.
        for (int c = 0; c < 1500; c++) begin
            s_tvalid = 4'($urandom);
            for (int i = 0; i < N; i++) s_tdata[i*W +: W] = $urandom;
            m_tready = ($urandom_range(0, 9) < 7);
            flush    = ($urandom_range(0, 19) == 0);
            cyc();
        end

        s_tvalid = '0;
        flush    = 1'b0;
        m_tready = 1'b1;
        repeat (3) cyc();
        @(negedge clk);
        #1;
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
